// File: rtl/picorv32_mem_pkg.sv
// Shared types and constants for the two-master PicoRV32 memory arbiter.
package picorv32_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'h0000_0000;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// Wait-cycle counter for a granted slave access; tc flags the timeout cycle.
module mem_timeout_counter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int unsigned W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + W'(1);
    end
  end

  // TIMEOUT == 0 disables the terminal count; the counter may then wrap harmlessly.
  assign tc = (TIMEOUT != 0) && (count_q == W'(TIMEOUT));

endmodule

// File: rtl/picorv32_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between two PicoRV32-style masters.
module picorv32_mem_arbiter
  import picorv32_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = DEFAULT_ERR_DATA
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,

  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,

  output logic        timeout_err
);

  arb_state_t  state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        err_q, set_err;
  logic        grant;
  logic        busy, tc, done;
  logic [31:0] rdata_sel;
  mem_req_t    req0, req1, req_sel;

  assign req0 = {m0_instr, m0_addr, m0_wdata, m0_wstrb};
  assign req1 = {m1_instr, m1_addr, m1_wdata, m1_wstrb};

  mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_wait_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clear  (!busy),
    .enable (busy && !s_ready),
    .tc     (tc)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      err_q   <= err_q | set_err;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    set_err = 1'b0;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          grant   = (m0_valid && m1_valid) ? !last_q : m1_valid;
          state_d = BUSY;
          owner_d = grant;
          last_d  = grant;
        end
      end
      BUSY: begin
        // A real response always wins over a coincident timeout.
        if (s_ready) begin
          state_d = IDLE;
        end else if (tc) begin
          state_d = IDLE;
          set_err = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == BUSY);
  assign req_sel   = owner_q ? req1 : req0;
  assign done      = busy && (s_ready || tc);
  assign rdata_sel = (tc && !s_ready) ? ERR_DATA : s_rdata;

  assign s_valid = busy;
  assign {s_instr, s_addr, s_wdata, s_wstrb} = busy ? req_sel : '0;

  assign m0_ready = done && !owner_q;
  assign m1_ready = done && owner_q;
  assign m0_rdata = (busy && !owner_q) ? rdata_sel : '0;
  assign m1_rdata = (busy && owner_q) ? rdata_sel : '0;

  assign timeout_err = err_q;

endmodule
